// File: rtl/mdu_iter_if.sv
// rtl/mdu_iter_if.sv - start/busy/valid handshake bundle for the iterative multiply/divide unit
//
// Purpose: groups the request, flush and result signals of mdu_iter.
// Ports (signals):
//   start, op[1:0], opr1, opr2, cancel : requester -> unit
//   busy, valid, hi, lo                : unit -> requester
// Modports: master (EX stage side), slave (mdu_iter side).
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opr1;
  logic [WIDTH-1:0] opr2;
  logic             cancel;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, opr1, opr2, cancel,
    input  busy, valid, hi, lo
  );

  modport slave (
    input  start, op, opr1, opr2, cancel,
    output busy, valid, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative one-bit-per-cycle MULT/MULTU/DIV/DIVU unit
//
// Purpose: shift-add multiply and restoring divide on operand magnitudes,
// with sign correction in a single DONE cycle; results are {hi,lo}.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mdu_iter_if.slave (start/op/opr1/opr2/cancel in; busy/valid/hi/lo out)
// Optional macro MDU_EARLY_TERM_EN: a zero opr2 skips CALC and finishes in cycle 1.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input logic       clk,
  input logic       rst,
  mdu_iter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_nx;
  logic [CNTW-1:0]    cnt;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   opb;      // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc;      // mult: {partial sum, multiplier}; div: {remainder, dividend/quotient}
  logic               neg_q;    // negate product / quotient
  logic               neg_r;    // negate remainder (signed dividend was negative)
  logic               dz;       // divisor was zero: quotient is left as all ones
  logic [WIDTH-1:0]   hi_r, lo_r;

  // Request decode and operand magnitudes
  logic             is_div, is_signed, s1, s2, accept, early;
  logic [WIDTH-1:0] mag1, mag2;

  assign is_div    = bus.op[1];
  assign is_signed = ~bus.op[0];
  assign s1        = is_signed & bus.opr1[WIDTH-1];
  assign s2        = is_signed & bus.opr2[WIDTH-1];
  assign mag1      = s1 ? -bus.opr1 : bus.opr1;
  assign mag2      = s2 ? -bus.opr2 : bus.opr2;
  assign accept    = (state == IDLE) && bus.start && !bus.cancel;

`ifdef MDU_EARLY_TERM_EN
  assign early = (bus.opr2 == '0);
`else
  assign early = 1'b0;
`endif

  // One iteration step
  logic [WIDTH:0]     msum, rshift;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    msum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    rshift   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    acc_step = {msum, acc[WIDTH-1:1]};
    if (op_r[1]) begin
      if (rshift >= {1'b0, opb}) begin
        acc_step = {rshift[WIDTH-1:0] - opb, acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = {rshift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign correction applied in DONE
  logic [WIDTH-1:0]   res_hi, res_lo, quo, rem;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    prod   = neg_q ? -acc : acc;
    quo    = acc[WIDTH-1:0];
    rem    = acc[2*WIDTH-1:WIDTH];
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (op_r[1]) begin
      res_lo = (neg_q && !dz) ? -quo : quo;
      res_hi = neg_r ? -rem : rem;  // also restores opr1 when dividing by zero
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = early ? DONE : CALC;
      CALC:    if (bus.cancel) state_nx = IDLE;
               else if (cnt == CNTW'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      op_r  <= '0;
      opb   <= '0;
      acc   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
      hi_r  <= '0;
      lo_r  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (accept) begin
          op_r  <= bus.op;
          opb   <= mag2;
          cnt   <= CNTW'(WIDTH);
          neg_q <= s1 ^ s2;
          neg_r <= s1 & is_div;
          dz    <= (bus.opr2 == '0);
          if (early) acc <= is_div ? {mag1, {WIDTH{1'b1}}} : '0;
          else       acc <= {{WIDTH{1'b0}}, mag1};
        end
        CALC: if (!bus.cancel) begin
          acc <= acc_step;
          cnt <= cnt - 1'b1;
        end
        DONE: if (!bus.cancel) begin
          hi_r <= res_hi;
          lo_r <= res_lo;
        end
        default: ;
      endcase
    end
  end

  // The result is presented in the DONE cycle itself and latched for later cycles.
  assign bus.busy  = (state != IDLE);
  assign bus.valid = (state == DONE) && !bus.cancel;
  assign bus.hi    = bus.valid ? res_hi : hi_r;
  assign bus.lo    = bus.valid ? res_lo : lo_r;
endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - self-checking bench for mdu_iter against an arithmetic reference model
module tb_mdu_iter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  logic [W-1:0] prev_hi = '0;
  logic [W-1:0] prev_lo = '0;

  always #5 clk = ~clk;

  mdu_iter_if #(.WIDTH(W)) bus ();
  mdu_iter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [2*W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [2*W-1:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    case (o)
      2'b00: r = 64'(sa * sb);
      2'b01: r = 64'(ua * ub);
      default: begin
        if (b == '0) begin
          r = {a, {W{1'b1}}};
        end else if (o == 2'b10) begin
          sq = sa / sb;
          sr = sa % sb;
          r = {sr[W-1:0], sq[W-1:0]};
        end else begin
          uq = ua / ub;
          ur = ua % ub;
          r = {ur[W-1:0], uq[W-1:0]};
        end
      end
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [W-1:0] b);
`ifdef MDU_EARLY_TERM_EN
    return (b == '0) ? 1 : W + 1;
`else
    return W + 1;
`endif
  endfunction

  // Issues one operation in the next cycle and checks busy/valid per cycle and the result.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input string name);
    logic [2*W-1:0] exp;
    int lat;
    exp = model(o, a, b);
    lat = exp_lat(b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.opr1 = a; bus.opr2 = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 2'($urandom); bus.opr1 = $urandom; bus.opr2 = $urandom;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== (c <= lat)) begin
        failures++;
        $display("FAIL %s busy cycle %0d: got %b want %b", name, c, bus.busy, (c <= lat));
      end
      checks++;
      if (bus.valid !== (c == lat)) begin
        failures++;
        $display("FAIL %s valid cycle %0d: got %b want %b", name, c, bus.valid, (c == lat));
      end
      if (c < lat) begin
        checks++;
        if ({bus.hi, bus.lo} !== {prev_hi, prev_lo}) begin
          failures++;
          $display("FAIL %s hold cycle %0d: got %h_%h want %h_%h", name, c, bus.hi, bus.lo, prev_hi, prev_lo);
        end
      end else begin
        checks++;
        if ({bus.hi, bus.lo} !== exp) begin
          failures++;
          $display("FAIL %s result cycle %0d: got hi=%h lo=%h want hi=%h lo=%h", name, c, bus.hi, bus.lo, exp[2*W-1:W], exp[W-1:0]);
        end
      end
    end
    {prev_hi, prev_lo} = exp;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.cancel = 1'b0; bus.op = '0; bus.opr1 = '0; bus.opr2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.valid, bus.hi, bus.lo} !== '0) begin
      failures++;
      $display("FAIL reset_state: got busy=%b valid=%b hi=%h lo=%h want all 0", bus.busy, bus.valid, bus.hi, bus.lo);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
    run_op(2'b00, 32'hFFFFFFFD, 32'd5, "mult_neg");
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, "div_neg");
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, "div_overflow");
    run_op(2'b11, 32'd5, 32'd0, "divu_zero");
    run_op(2'b10, 32'hFFFFFFF9, 32'd0, "div_zero_neg");
    run_op(2'b00, 32'h12345678, 32'd0, "mult_zero");
    run_op(2'b10, 32'd7, 32'hFFFFFFFE, "div_pos_by_neg");
  endtask

  task automatic test_random();
    logic [1:0] o;
    logic [W-1:0] a, b;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
        3: b = 32'($urandom_range(0, 15)) - 32'd8;
        default: ;
      endcase
      run_op(o, a, b, "random");
    end
  endtask

  task automatic test_cancel();
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b11; bus.opr1 = 32'd100; bus.opr2 = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.cancel = 1'b1;
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    for (int c = 11; c < 45; c++) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
        failures++;
        $display("FAIL cancel_idle cycle %0d: got busy=%b valid=%b want 0 0", c, bus.busy, bus.valid);
      end
      checks++;
      if ({bus.hi, bus.lo} !== {prev_hi, prev_lo}) begin
        failures++;
        $display("FAIL cancel_hold cycle %0d: got %h_%h want %h_%h", c, bus.hi, bus.lo, prev_hi, prev_lo);
      end
    end
    run_op(2'b11, 32'd100, 32'd7, "divu_after_cancel");
  endtask

  task automatic test_start_ignored();
    logic [2*W-1:0] exp;
    exp = model(2'b01, 32'hDEADBEEF, 32'h0000ABCD);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.opr1 = 32'hDEADBEEF; bus.opr2 = 32'h0000ABCD;
    @(posedge clk); #1;
    for (int c = 1; c <= W + 2; c++) begin
      bus.start = (c == 5 || c == 20);
      bus.op = 2'($urandom); bus.opr1 = $urandom; bus.opr2 = $urandom;
      @(negedge clk);
      checks++;
      if (bus.valid !== (c == W + 1)) begin
        failures++;
        $display("FAIL ignore_start valid cycle %0d: got %b want %b", c, bus.valid, (c == W + 1));
      end
      if (c == W + 1) begin
        checks++;
        if ({bus.hi, bus.lo} !== exp) begin
          failures++;
          $display("FAIL ignore_start result: got %h_%h want %h_%h", bus.hi, bus.lo, exp[2*W-1:W], exp[W-1:0]);
        end
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    {prev_hi, prev_lo} = exp;
    // start and cancel together in IDLE: request is dropped
    bus.start = 1'b1; bus.cancel = 1'b1; bus.opr2 = 32'd1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.cancel = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
        failures++;
        $display("FAIL start_cancel_idle: got busy=%b valid=%b want 0 0", bus.busy, bus.valid);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.opr1 = 32'h0F0F0F0F; bus.opr2 = 32'h33333333;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (11) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.valid, bus.hi, bus.lo} !== '0) begin
      failures++;
      $display("FAIL async_reset: got busy=%b valid=%b hi=%h lo=%h want all 0", bus.busy, bus.valid, bus.hi, bus.lo);
    end
    @(negedge clk);
    rst = 1'b0;
    prev_hi = '0;
    prev_lo = '0;
    run_op(2'b01, 32'd3, 32'd4, "multu_after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_cancel();
    test_start_ignored();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
